// File: rtl/cfu_initiator_pkg.sv
// Shared types and constants for the CFU command/response initiator.
package cfu_initiator_pkg;

    localparam int FUNC_ID_W = 10;
    localparam int DATA_W    = 32;
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

endpackage

// File: rtl/cfu_initiator_if.sv
// Bus bundle for the initiator: upstream request, CFU cmd/rsp, downstream result and status.
interface cfu_initiator_if #(
    parameter int CNT_W = 16
);
    import cfu_initiator_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [FUNC_ID_W-1:0] req_function_id;
    logic [DATA_W-1:0]    req_inputs_0;
    logic [DATA_W-1:0]    req_inputs_1;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [FUNC_ID_W-1:0] cmd_payload_function_id;
    logic [DATA_W-1:0]    cmd_payload_inputs_0;
    logic [DATA_W-1:0]    cmd_payload_inputs_1;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_payload_outputs_0;

    logic                 res_valid;
    logic                 res_ready;
    logic [DATA_W-1:0]    res_data;
    logic                 res_error;

    logic                 busy;
    logic [CNT_W-1:0]     done_count;

    modport master (
        input  req_valid, req_function_id, req_inputs_0, req_inputs_1,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0, res_ready,
        output req_ready, cmd_valid, cmd_payload_function_id,
        output cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready, res_valid, res_data, res_error, busy, done_count
    );

    modport slave (
        output req_valid, req_function_id, req_inputs_0, req_inputs_1,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0, res_ready,
        input  req_ready, cmd_valid, cmd_payload_function_id,
        input  cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready, res_valid, res_data, res_error, busy, done_count
    );

endinterface

// File: rtl/cfu_initiator_watchdog.sv
// Transaction watchdog: down-counter loaded on clear, flags expiry at terminal count while enabled.
module cfu_initiator_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_remain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remain <= '0;
        end else if (i_clear) begin
            r_remain <= LOAD;
        end else if (i_enable && (r_remain != '0)) begin
            r_remain <= r_remain - CW'(1);
        end
    end

    assign o_expired = i_enable && (r_remain == '0);

endmodule

// File: rtl/cfu_initiator.sv
// CFU initiator: one outstanding op from request stream to CFU and back to result stream.
// Optional watchdog abort is built when CFU_INITIATOR_TIMEOUT_EN is defined.
//
// state      | meaning
// ST_IDLE    | ready for a request; stray responses drained
// ST_ISSUE   | cmd_valid high with registered payload, awaiting cmd_ready
// ST_WAIT    | awaiting CFU response
// ST_DELIVER | res_valid high, awaiting res_ready
module cfu_initiator
    import cfu_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    cfu_initiator_if.master bus
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [FUNC_ID_W-1:0] r_fid;
    logic [DATA_W-1:0]    r_in0;
    logic [DATA_W-1:0]    r_in1;
    logic [DATA_W-1:0]    r_res_data;
    logic [CNT_W-1:0]     r_done_count;
    logic                 w_req_hs;
    logic                 w_res_hs;
    logic                 w_rsp_take;
    logic                 w_timeout;
    logic                 w_wd_expired;
    logic                 w_res_error;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_req_hs = (r_state == ST_IDLE) && bus.req_valid;
    assign w_res_hs = (r_state == ST_DELIVER) && bus.res_ready;

`ifdef CFU_INITIATOR_TIMEOUT_EN
    logic r_res_error;

    cfu_initiator_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_req_hs),
        .i_enable ((r_state == ST_ISSUE) || (r_state == ST_WAIT)),
        .o_expired(w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_error <= 1'b0;
        end else if (w_rsp_take) begin
            r_res_error <= 1'b0;
        end else if (w_timeout) begin
            r_res_error <= 1'b1;
        end
    end

    assign w_res_error = r_res_error;
`else
    assign w_wd_expired = 1'b0;
    assign w_res_error  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A handshake in the same cycle as expiry takes priority over the abort.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_DELIVER;
                    w_timeout   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.rsp_valid) begin
                    w_state_nxt = ST_DELIVER;
                    w_rsp_take  = 1'b1;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_DELIVER;
                    w_timeout   = 1'b1;
                end
            end
            ST_DELIVER: begin
                if (bus.res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fid        <= '0;
            r_in0        <= '0;
            r_in1        <= '0;
            r_res_data   <= '0;
            r_done_count <= '0;
        end else begin
            if (w_req_hs) begin
                r_fid <= bus.req_function_id;
                r_in0 <= bus.req_inputs_0;
                r_in1 <= bus.req_inputs_1;
            end
            if (w_rsp_take) begin
                r_res_data <= bus.rsp_payload_outputs_0;
            end else if (w_timeout) begin
                r_res_data <= TIMEOUT_DATA;
            end
            if (w_res_hs && !w_res_error) begin
                r_done_count <= r_done_count + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready               = (r_state == ST_IDLE);
    assign bus.cmd_valid               = (r_state == ST_ISSUE);
    assign bus.rsp_ready               = (r_state != ST_ISSUE);
    assign bus.res_valid               = (r_state == ST_DELIVER);
    assign bus.busy                    = (r_state != ST_IDLE);
    assign bus.cmd_payload_function_id = r_fid;
    assign bus.cmd_payload_inputs_0    = r_in0;
    assign bus.cmd_payload_inputs_1    = r_in1;
    assign bus.res_data                = r_res_data;
    assign bus.res_error               = w_res_error;
    assign bus.done_count              = r_done_count;

endmodule
